// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IFU reads and LSU reads/writes
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [2:0]            lsu_len,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_resp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_len,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err_timeout
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  // Counter value at which the next WAIT cycle completes TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state;
  logic                  own_lsu_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            len_q;
  logic [SW-1:0]         starve_cnt;
  logic [7:0]            tmo_cnt;
  logic                  ifu_grant;
  logic                  lsu_grant;
  logic                  issuing;

  // Grant in IDLE: LSU has priority unless the IFU has lost STARVE_LIMIT times in a row.
  always_comb begin
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (rst_n && state == S_IDLE) begin
      ifu_grant = ifu_req_valid && (!lsu_req_valid || starve_cnt == STARVE_MAX);
      lsu_grant = lsu_req_valid && !ifu_grant;
    end
  end

  assign ifu_req_ready = ifu_grant;
  assign lsu_req_ready = lsu_grant;

  // Memory request fields are driven from the latched request only while issuing, else zero.
  always_comb begin
    issuing       = (state == S_ISSUE);
    mem_req_valid = issuing;
    mem_wen       = issuing & wen_q;
    mem_addr      = issuing ? addr_q  : '0;
    mem_wdata     = issuing ? wdata_q : '0;
    mem_len       = issuing ? len_q   : 3'd0;
  end

  // Transaction FSM: latch request, issue to memory, wait for response, pulse owner's response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      own_lsu_q      <= 1'b0;
      wen_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      len_q          <= 3'd0;
      starve_cnt     <= '0;
      tmo_cnt        <= 8'd0;
      err_timeout    <= 1'b0;
      ifu_resp_valid <= 1'b0;
      ifu_resp_data  <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_resp_data  <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (lsu_grant) begin
            own_lsu_q <= 1'b1;
            wen_q     <= lsu_wen;
            addr_q    <= lsu_addr;
            wdata_q   <= lsu_wdata;
            len_q     <= lsu_len;
            state     <= S_ISSUE;
            if (ifu_req_valid && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (ifu_grant) begin
            own_lsu_q  <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= ifu_addr;
            wdata_q    <= '0;
            len_q      <= 3'd4;
            starve_cnt <= '0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready) begin
            tmo_cnt <= 8'd0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
          if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
          end
          if (mem_resp_valid) begin
            state <= S_RESP;
            if (own_lsu_q) begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= wen_q ? '0 : mem_rdata;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_resp_data  <= mem_rdata;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
